// File: rtl/memory_responder.sv
// Memory-side responder for the 16-bit datapath memory port: a RAM with
// one-cycle registered reads plus a 16-word I/O page holding a cycle
// counter, sticky button events, an LED register and an output FIFO.
module memory_responder #(
    parameter int          RAM_ADDR_WIDTH = 12,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          BUTTON_WIDTH   = 4,
    parameter logic [15:0] IO_BASE        = 16'hFF00
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [15:0]             memory_address,
    input  logic [15:0]             memory_write_data,
    input  logic                    memory_write_enable,
    input  logic                    memory_read_enable,
    output logic [15:0]             memory_read_data,
    input  logic [BUTTON_WIDTH-1:0] buttons,
    output logic [15:0]             leds,
    output logic [15:0]             fifo_data,
    output logic                    fifo_valid,
    input  logic                    fifo_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Address decode; the I/O page is assumed 16-word aligned.
    logic                      ram_sel, io_sel, io_rd, io_wr;
    logic [3:0]                io_idx;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    assign ram_sel  = (memory_address >> RAM_ADDR_WIDTH) == 16'd0;
    assign io_sel   = memory_address[15:4] == IO_BASE[15:4];
    assign io_idx   = memory_address[3:0];
    assign ram_addr = memory_address[RAM_ADDR_WIDTH-1:0];
    assign io_rd    = memory_read_enable & io_sel;
    assign io_wr    = memory_write_enable & io_sel;

    logic [15:0]             ram_q [0:(1<<RAM_ADDR_WIDTH)-1];
    logic [15:0]             rdata_q, rdata_d, leds_q, shadow_q;
    logic [31:0]             cnt_q;
    logic [BUTTON_WIDTH-1:0] sync1_q, sync2_q, prev_q, sticky_q, sticky_d, btn_edge;
    logic [15:0]             fbuf_q [0:FIFO_DEPTH-1];
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [15:0]             head_q, head_d;
    logic                    ovf_q, ovf_d;
    logic                    full, empty, push, pop, push_ok, drop;

    // RAM array has no reset; the registered read below sees pre-write data.
    always_ff @(posedge clock) begin
        if (memory_write_enable && ram_sel) ram_q[ram_addr] <= memory_write_data;
    end

    // Read mux: everything a load could return this cycle, before side effects.
    always_comb begin
        rdata_d = 16'd0;
        if (ram_sel) begin
            rdata_d = ram_q[ram_addr];
        end else if (io_sel) begin
            case (io_idx)
                4'd0:    rdata_d = cnt_q[15:0];
                4'd1:    rdata_d = shadow_q;
                4'd2:    rdata_d = 16'(sticky_q);
                4'd3:    rdata_d = leds_q;
                4'd5:    rdata_d = {ovf_q, full, empty, 8'd0, 5'(count_q)};
                default: rdata_d = 16'd0;
            endcase
        end
    end

    // Read data register, free-running counter, high-half shadow and LEDs.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q  <= 16'd0;
            cnt_q    <= 32'd0;
            shadow_q <= 16'd0;
            leds_q   <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (memory_read_enable) rdata_q <= rdata_d;
            if (io_rd && io_idx == 4'd0) shadow_q <= cnt_q[31:16];
            if (io_wr && io_idx == 4'd3) leds_q <= memory_write_data;
        end
    end

    // A new edge wins over a clear-on-read landing in the same cycle.
    assign btn_edge = sync2_q & ~prev_q;
    assign sticky_d = ((io_rd && io_idx == 4'd2) ? '0 : sticky_q) | btn_edge;

    // Button synchronizer, edge-detect history and sticky capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            sticky_q <= '0;
        end else begin
            sync1_q  <= buttons;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            sticky_q <= sticky_d;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head pops.
    assign full    = count_q == DEPTH_C;
    assign empty   = count_q == '0;
    assign pop     = !empty && fifo_ready;
    assign push    = io_wr && io_idx == 4'd4;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    assign rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    assign count_d = count_q + CW'(push_ok) - CW'(pop);
    assign ovf_d   = ((io_rd && io_idx == 4'd5) ? 1'b0 : ovf_q) | drop;

    // Next head word; bypass the buffer when the new head is this cycle's push.
    always_comb begin
        head_d = fbuf_q[rptr_d];
        if (count_d == '0)                  head_d = 16'd0;
        else if (push_ok && wptr_q == rptr_d) head_d = memory_write_data;
    end

    // FIFO storage has no reset; only entries between the pointers matter.
    always_ff @(posedge clock) begin
        if (push_ok) fbuf_q[wptr_q] <= memory_write_data;
    end

    // FIFO pointers, count, overflow sticky and registered head.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            head_q  <= 16'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            head_q  <= head_d;
        end
    end

    assign memory_read_data = rdata_q;
    assign leds             = leds_q;
    assign fifo_data        = head_q;
    assign fifo_valid       = !empty;
endmodule

// File: tb/tb_memory_responder.sv
// Randomised bench for memory_responder with a scoreboard: the driver
// predicts each edge from a behavioural model, a monitor compares outputs.
module tb_memory_responder;
    localparam int          AW  = 12;
    localparam int          D   = 8;
    localparam int          BW  = 4;
    localparam logic [15:0] IOB = 16'hFF00;

    logic          clock = 1'b0;
    logic          reset;
    logic [15:0]   memory_address, memory_write_data, memory_read_data;
    logic          memory_write_enable, memory_read_enable;
    logic [BW-1:0] buttons;
    logic [15:0]   leds, fifo_data;
    logic          fifo_valid, fifo_ready;

    memory_responder #(.RAM_ADDR_WIDTH(AW), .FIFO_DEPTH(D), .BUTTON_WIDTH(BW), .IO_BASE(IOB)) dut (
        .clock(clock), .reset(reset),
        .memory_address(memory_address), .memory_write_data(memory_write_data),
        .memory_write_enable(memory_write_enable), .memory_read_enable(memory_read_enable),
        .memory_read_data(memory_read_data), .buttons(buttons), .leds(leds),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready)
    );

    always #5 clock = ~clock;

    int total = 0, passed = 0;

    // Scoreboard queues: expected load results, and words held in the FIFO.
    logic [15:0] rd_q[$];
    logic [15:0] sb[$];

    // Behavioural model state.
    logic [15:0]   m_ram [int];
    int unsigned   m_cnt = 0;
    logic [15:0]   m_shadow = 0, m_leds = 0;
    logic [BW-1:0] m_sticky = 0;
    logic [BW-1:0] seen [3];   // buttons as sampled 1, 2 and 3 edges ago
    logic          m_ovf = 0;
    logic [BW-1:0] btn = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Drive one edge's inputs, apply that edge to the model, then move past the edge.
    task automatic step(input logic rst, input logic [15:0] a, input logic [15:0] wd,
                        input logic we, input logic re, input logic rdy);
        logic [15:0]   rv;
        logic [BW-1:0] rise;
        bit            ram, io;
        int            n;
        reset = rst; memory_address = a; memory_write_data = wd;
        memory_write_enable = we; memory_read_enable = re; fifo_ready = rdy; buttons = btn;
        if (rst) begin
            m_cnt = 0; m_shadow = 0; m_leds = 0; m_sticky = 0; m_ovf = 0;
            seen[0] = 0; seen[1] = 0; seen[2] = 0;
            sb.delete();
        end else begin
            ram = int'(a) < (1 << AW);
            io  = a >= IOB && int'(a) < int'(IOB) + 16;
            n   = int'(a) - int'(IOB);
            rv  = 16'h0;
            if (ram) rv = m_ram.exists(int'(a)) ? m_ram[int'(a)] : 16'h0;
            else if (io) begin
                case (n)
                    0: rv = m_cnt[15:0];
                    1: rv = m_shadow;
                    2: rv = 16'(m_sticky);
                    3: rv = m_leds;
                    5: rv = {m_ovf, sb.size() == D, sb.size() == 0, 8'h0, 5'(sb.size())};
                    default: rv = 16'h0;
                endcase
            end
            rise = seen[1] & ~seen[2];
            if (re) begin
                rd_q.push_back(rv);
                if (io && n == 0) m_shadow = m_cnt[31:16];
                if (io && n == 5) m_ovf = 1'b0;
            end
            m_sticky = ((re && io && n == 2) ? '0 : m_sticky) | rise;
            if (we && io && n == 4) begin
                if (sb.size() < D || rdy) sb.push_back(wd);
                else m_ovf = 1'b1;
            end
            if (we && io && n == 3) m_leds = wd;
            if (we && ram) m_ram[int'(a)] = wd;
            m_cnt++;
            seen[2] = seen[1]; seen[1] = seen[0]; seen[0] = btn;
        end
        @(posedge clock); #2;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] wd, input logic rdy);
        step(1'b0, a, wd, 1'b1, 1'b0, rdy);
    endtask
    task automatic rd(input logic [15:0] a, input logic rdy);
        step(1'b0, a, 16'h0, 1'b0, 1'b1, rdy);
    endtask
    task automatic idle(input logic rdy);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, rdy);
    endtask

    // Monitor: 1 time unit after each edge, compare outputs against the scoreboard.
    initial begin
        logic        pv = 1'b0;
        logic [15:0] pd = 16'h0;
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                check("reset_read_data", memory_read_data, 16'h0);
                check("reset_fifo_data", fifo_data, 16'h0);
            end else begin
                if (memory_read_enable) begin
                    if (rd_q.size() == 0) check("read_unexpected", 1, 0);
                    else check("read_data", memory_read_data, rd_q.pop_front());
                end
                if (pv && fifo_ready) begin
                    if (sb.size() == 0) check("fifo_pop_empty", 1, 0);
                    else check("fifo_pop_word", pd, sb.pop_front());
                end
            end
            check("fifo_valid", fifo_valid, sb.size() != 0);
            if (sb.size() != 0) check("fifo_head", fifo_data, sb[0]);
            check("leds", leds, m_leds);
            pv = fifo_valid;
            pd = fifo_data;
        end
    end

    logic [15:0] pool [8] = '{16'h0010, 16'h0020, 16'h0030, 16'h0031,
                              16'h0777, 16'h0FFE, 16'h0FFF, 16'h0000};

    initial begin
        int r;
        logic [15:0] a;
        seen[0] = 0; seen[1] = 0; seen[2] = 0;
        step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        foreach (pool[i]) wr(pool[i], 16'($urandom), 1'b0);

        // RAM basics, unmapped read, read-first collision
        wr(16'h0010, 16'h1234, 1'b0);
        rd(16'h0010, 1'b0);
        rd(16'h2000, 1'b0);
        wr(16'h0020, 16'h5555, 1'b0);
        step(1'b0, 16'h0020, 16'hAAAA, 1'b1, 1'b1, 1'b0);
        rd(16'h0020, 1'b0);
        rd(16'hFEFF, 1'b0);
        wr(16'h8000, 16'hDEAD, 1'b0);
        rd(16'h8000, 1'b0);

        // LEDs: same-cycle read/write returns old value
        wr(IOB + 3, 16'h0F0F, 1'b0);
        step(1'b0, IOB + 3, 16'h1357, 1'b1, 1'b1, 1'b0);
        rd(IOB + 3, 1'b0);
        wr(IOB + 0, 16'hFFFF, 1'b0);
        rd(IOB + 0, 1'b0);

        // FIFO overflow, status, drain
        for (int i = 1; i <= 9; i++) wr(IOB + 4, 16'(i), 1'b0);
        rd(IOB + 5, 1'b0);
        rd(IOB + 4, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b1);
        rd(IOB + 5, 1'b1);
        step(1'b0, IOB + 4, 16'h00AB, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Buttons: pulse, clear-on-read, edge coinciding with the clear
        btn = 4'b0100;
        repeat (4) idle(1'b0);
        btn = 4'b0000;
        repeat (3) idle(1'b0);
        rd(IOB + 2, 1'b0);
        rd(IOB + 2, 1'b0);
        btn = 4'b0100;
        idle(1'b0);
        idle(1'b0);
        rd(IOB + 2, 1'b0);
        rd(IOB + 2, 1'b0);
        btn = 4'b0000;

        // Random traffic until the counter approaches the low-half wrap
        while (m_cnt < 32'h0000FFE0) begin
            logic rdy;
            rdy = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 63) == 0) btn = btn ^ BW'(1 << $urandom_range(0, BW - 1));
            r = $urandom_range(0, 9);
            case (r)
                0, 1: step(1'b0, pool[$urandom_range(1, 7)], 16'($urandom), 1'b1, 1'($urandom), rdy);
                2, 3, 8: rd(pool[$urandom_range(0, 7)], rdy);
                4: rd(IOB + 16'($urandom_range(0, 15)), rdy);
                5: begin
                    a = IOB + 16'($urandom_range(0, 15));
                    step(1'b0, a, 16'($urandom), 1'b1, 1'($urandom), rdy);
                end
                6: wr(IOB + 4, 16'($urandom), rdy);
                7: step(1'b0, 16'($urandom_range(32'h1000, 32'hFEFF)), 16'($urandom),
                        1'($urandom), 1'($urandom), rdy);
                default: idle(rdy);
            endcase
        end

        // Counter snapshot across the low-half wrap
        btn = 0;
        while (m_cnt != 32'h0000FFFF) idle(1'b1);
        rd(IOB + 0, 1'b1);
        rd(IOB + 1, 1'b1);
        idle(1'b1);
        rd(IOB + 0, 1'b1);
        rd(IOB + 1, 1'b1);

        // Mid-operation reset with FIFO entries and LEDs set
        wr(IOB + 3, 16'h00FF, 1'b0);
        for (int i = 0; i < 3; i++) wr(IOB + 4, 16'h0100 + 16'(i), 1'b0);
        idle(1'b0);
        step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        rd(16'h0010, 1'b0);
        rd(IOB + 0, 1'b0);
        rd(IOB + 5, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
